temp_adc_sampler: RTL and testbench

Upstream acquisition stage for the temperature monitor. Periodically reads a serial (SPI-style) 10-bit temperature ADC and averages a 2^AVG_LOG2 sample moving window. Emits temp_data with a one-cycle temp_valid strobe, which feed the monitor's temp_in/temp_valid inputs directly.

---
 rtl/temp_adc_sampler.sv | 174 +++++++++++++++++
 tb/tb_temp_adc_sampler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/temp_adc_sampler.sv
// temp_adc_sampler: periodic serial 10-bit ADC reader with moving-average window.
// Ports: clk, rst (async active-low), enable, adc_cs_n/adc_sclk/adc_miso (ADC link),
//   temp_data/temp_valid (averaged output + strobe), frame_err, spike, busy.
// Optional: define TEMP_SPIKE_REJECT_EN to drop post-warm-up samples that jump
//   more than SPIKE_LIMIT from temp_data (spike strobe instead of temp_valid).
module temp_adc_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int SPIKE_LIMIT   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  input  logic       adc_miso,
  output logic [9:0] temp_data,
  output logic       temp_valid,
  output logic       frame_err,
  output logic       spike,
  output logic       busy
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 10 + AVG_LOG2;
  localparam int PW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW    = AVG_LOG2 + 1;

  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] WP_LAST  = AW'(DEPTH - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_PRE = FW'(DEPTH - 1);

`ifdef TEMP_SPIKE_REJECT_EN
  localparam bit SPIKE_EN = 1'b1;
`else
  localparam bit SPIKE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    FINISH,
    ACCUM
  } state_t;

  state_t        state;
  logic [PW-1:0] per_cnt;
  logic [DW-1:0] div;
  logic [3:0]    bit_cnt;
  logic [11:0]   sh;
  logic [9:0]    win [DEPTH];
  logic [AW-1:0] wp;
  logic [FW-1:0] fill;
  logic [SW-1:0] sum;

  logic [9:0]        raw;
  logic [9:0]        oldest;
  logic              null_ok;
  logic              full;
  logic [SW:0]       sum_ext;
  logic [SW-1:0]     sum_nxt;
  logic signed [10:0] diff;
  logic [10:0]       mag;
  logic              is_spike;

  assign raw     = sh[9:0];
  assign null_ok = (sh[11:10] == 2'b00);
  assign oldest  = win[wp];
  assign full    = (fill == FILL_MAX);

  // Oldest slot is zero during warm-up, so sum is always the window total.
  assign sum_ext = {1'b0, sum}
                 + {{(SW-9){1'b0}}, raw}
                 - {{(SW-9){1'b0}}, oldest};
  assign sum_nxt = sum_ext[SW-1:0];

  assign diff     = $signed({1'b0, raw}) - $signed({1'b0, temp_data});
  assign mag      = diff[10] ? 11'(-diff) : 11'(diff);
  assign is_spike = SPIKE_EN && full && (mag > 11'(SPIKE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      div        <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      wp         <= '0;
      fill       <= '0;
      sum        <= '0;
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b0;
      temp_data  <= '0;
      temp_valid <= 1'b0;
      frame_err  <= 1'b0;
      spike      <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else begin
      temp_valid <= 1'b0;
      frame_err  <= 1'b0;
      spike      <= 1'b0;

      if (!enable || per_cnt == PER_LAST) per_cnt <= '0;
      else per_cnt <= per_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (enable && per_cnt == PER_LAST) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
            div      <= '0;
          end
        end
        SETUP: begin
          if (div == DIV_LAST) begin
            div      <= '0;
            bit_cnt  <= '0;
            adc_sclk <= 1'b1;
            sh       <= {sh[10:0], adc_miso};
            state    <= SHIFT;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT: begin
          if (div != DIV_LAST) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            if (adc_sclk) begin
              adc_sclk <= 1'b0;
            end else if (bit_cnt == 4'd11) begin
              adc_cs_n <= 1'b1;
              state    <= FINISH;
            end else begin
              adc_sclk <= 1'b1;
              sh       <= {sh[10:0], adc_miso};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        FINISH: state <= ACCUM;
        ACCUM: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!null_ok) begin
            frame_err <= 1'b1;
          end else if (is_spike) begin
            spike <= 1'b1;
          end else begin
            win[wp] <= raw;
            wp      <= (wp == WP_LAST) ? '0 : wp + 1'b1;
            sum     <= sum_nxt;
            if (!full) fill <= fill + 1'b1;
            if (fill >= FILL_PRE) begin
              temp_data  <= sum_nxt[SW-1:AVG_LOG2];
              temp_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_adc_sampler.sv
// tb_temp_adc_sampler: directed bench for temp_adc_sampler.
// Serial ADC model returns adc_word per frame; expectations are hand-computed.
module tb_temp_adc_sampler;

  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 64;
  localparam int AVG_LOG2      = 2;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       enable   = 1'b0;
  logic       adc_miso = 1'b0;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [9:0] temp_data;
  logic       temp_valid;
  logic       frame_err;
  logic       spike;
  logic       busy;

  logic [11:0] adc_word = 12'd400;
  int total    = 0;
  int bad      = 0;
  int rise_cnt = 0;
  int cs_falls = 0;

  always #5 clk = ~clk;

  temp_adc_sampler #(
    .CLK_DIV(CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .AVG_LOG2(AVG_LOG2),
    .SPIKE_LIMIT(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk),
    .adc_miso(adc_miso),
    .temp_data(temp_data),
    .temp_valid(temp_valid),
    .frame_err(frame_err),
    .spike(spike),
    .busy(busy)
  );

  logic [11:0] fw = '0;
  int          bi = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;

  // ADC: MSB on cs_n fall, next bit after each sclk fall.
  always @(negedge clk) begin
    if (prev_cs && !adc_cs_n) begin
      fw       <= adc_word;
      bi       <= 11;
      adc_miso <= adc_word[11];
    end else if (!adc_cs_n && prev_sclk && !adc_sclk && bi > 0) begin
      bi       <= bi - 1;
      adc_miso <= fw[bi-1];
    end
    prev_cs   <= adc_cs_n;
    prev_sclk <= adc_sclk;
  end

  always @(posedge adc_sclk) rise_cnt <= rise_cnt + 1;
  always @(negedge adc_cs_n) cs_falls <= cs_falls + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic [11:0] w, input int drop_at,
                          output logic v, output logic e, output logic s,
                          output int lat, output int rises,
                          output logic [9:0] d0);
    int r0;
    bit ok;
    adc_word = w;
    v = 0; e = 0; s = 0; lat = -1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!adc_cs_n) begin ok = 1; break; end
    end
    check("cs_fall", 32'(ok), 1);
    r0 = rise_cnt;
    d0 = temp_data;
    if (drop_at > 0) begin
      repeat (drop_at) @(negedge clk);
      enable = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (adc_cs_n) begin ok = 1; break; end
    end
    check("cs_rise", 32'(ok), 1);
    rises = rise_cnt - r0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (temp_valid) begin v = 1; lat = k; end
      if (frame_err) e = 1;
      if (spike) s = 1;
    end
  endtask

  initial begin
    logic v, e, s;
    logic [9:0] d0;
    int lat, rises, f0, r0;
    int exp_d [4];
    bit ok;
    exp_d[0] = 500; exp_d[1] = 600; exp_d[2] = 700; exp_d[3] = 800;

    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(adc_cs_n), 1);
    check("rst_sclk", 32'(adc_sclk), 0);
    check("rst_data", 32'(temp_data), 0);
    check("rst_valid", 32'(temp_valid), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_spike", 32'(spike), 0);
    check("rst_busy", 32'(busy), 0);

    rst = 1'b1;
    f0 = cs_falls;
    repeat (500) @(negedge clk);
    check("disabled_falls", 32'(cs_falls - f0), 0);
    check("disabled_cs_n", 32'(adc_cs_n), 1);

    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_frame(12'd400, 0, v, e, s, lat, rises, d0);
      check("warm_valid", 32'(v), 0);
      check("warm_rises", 32'(rises), 12);
      check("warm_data", 32'(temp_data), 0);
    end
    do_frame(12'd400, 0, v, e, s, lat, rises, d0);
    check("f4_valid", 32'(v), 1);
    check("f4_latency", 32'(lat), 2);
    check("f4_data", 32'(temp_data), 400);
    check("f4_rises", 32'(rises), 12);

    for (int i = 0; i < 4; i++) begin
      do_frame(12'd800, 0, v, e, s, lat, rises, d0);
      check("ramp_hold", 32'(d0), (i == 0) ? 400 : 32'(exp_d[i-1]));
      check("ramp_valid", 32'(v), 1);
      check("ramp_data", 32'(temp_data), 32'(exp_d[i]));
    end

    do_frame({2'b01, 10'd900}, 0, v, e, s, lat, rises, d0);
    check("null_err", 32'(e), 1);
    check("null_valid", 32'(v), 0);
    check("null_data", 32'(temp_data), 800);
    do_frame(12'd800, 0, v, e, s, lat, rises, d0);
    check("post_err_valid", 32'(v), 1);
    check("post_err_data", 32'(temp_data), 800);

    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!adc_cs_n) begin ok = 1; break; end
    end
    check("mid_cs_fall", 32'(ok), 1);
    r0 = rise_cnt;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rise_cnt - r0 >= 6) begin ok = 1; break; end
    end
    check("mid_6th_sclk", 32'(ok), 1);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("mid_cs_n", 32'(adc_cs_n), 1);
    check("mid_sclk", 32'(adc_sclk), 0);
    check("mid_data", 32'(temp_data), 0);
    check("mid_busy_clr", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      do_frame(12'd400, 0, v, e, s, lat, rises, d0);
      check("rewarm_valid", 32'(v), 0);
    end
    do_frame(12'd400, 0, v, e, s, lat, rises, d0);
    check("rewarm_f4_valid", 32'(v), 1);
    check("rewarm_f4_data", 32'(temp_data), 400);

    do_frame(12'd550, 0, v, e, s, lat, rises, d0);
`ifdef TEMP_SPIKE_REJECT_EN
    check("spike_pulse", 32'(s), 1);
    check("spike_valid", 32'(v), 0);
    check("spike_data", 32'(temp_data), 400);
`else
    check("spike_pulse", 32'(s), 0);
    check("spike_valid", 32'(v), 1);
    check("spike_data", 32'(temp_data), 437);
`endif

    do_frame(12'd400, 10, v, e, s, lat, rises, d0);
    check("drop_valid", 32'(v), 1);
`ifdef TEMP_SPIKE_REJECT_EN
    check("drop_data", 32'(temp_data), 400);
`else
    check("drop_data", 32'(temp_data), 437);
`endif
    f0 = cs_falls;
    repeat (300) @(negedge clk);
    check("drop_idle_falls", 32'(cs_falls - f0), 0);
    check("drop_idle_cs_n", 32'(adc_cs_n), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
